btn_cmd_scheduler: RTL and testbench
====================================

# btn_cmd_scheduler

Debounces `N_BTN` raw push-buttons on a shared sample tick and converts each debounced press into a one-shot command. A single command port (valid/ready) is shared among the buttons with round-robin arbitration. Sits between board buttons and the program-counter/shifter control logic; replaces per-button free-running shift-register debouncers with one scheduled resource.

## Interface
- `N_BTN`, 4: number of buttons (2..16).
- `TICK_DIV`, 50000: clk cycles per debounce sample tick (≥1; 1 = every cycle).
- `STABLE`, 19: consecutive disagreeing ticks required to flip a debounced level (≥2).
- `IDW`, clog2(`N_BTN`): width of command id (derived; not overridden).

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in `N_BTN`: asynchronous raw button inputs, active-high.
- `btn_level` out `N_BTN`: debounced button levels.
- `cmd_valid` out 1: command offered.
- `cmd_id` out `IDW`: index of pressed button; stable while `cmd_valid`.
- `cmd_ready` in 1: consumer accepts; transfer on edge with `cmd_valid & cmd_ready`.
- `overrun` out `N_BTN`: sticky; press lost because one was already pending.
- `clr_overrun` in 1: clears all `overrun` bits.

## Operation
- Reset: `btn_level`=0, `cmd_valid`=0, `cmd_id`=0, `overrun`=0, pending=0, synchronizers=0, prescaler=0, per-button counters=0, rr pointer=0, FSM=IDLE.
- Synchronizer: 2 flops per button; `sync[i]` is `btn_raw[i]` delayed 2 edges.
- Prescaler: counts 0..`TICK_DIV`-1, wraps to 0; `tick`=1 when count==`TICK_DIV`-1.
- Debounce counter per button (width clog2(`STABLE`)): on tick, if `sync[i]`≠`btn_level[i]` then increment; on the tick where counter==`STABLE`-1, flip `btn_level[i]` and zero counter. If `sync[i]`==`btn_level[i]` on a tick, zero counter. No change between ticks.
- Press event: edge where `btn_level[i]` flips 0→1 also sets `pending[i]`. If `pending[i]` already 1, set `overrun[i]`. Releases generate nothing.
- FSM IDLE: if any pending, grant first pending index searching upward (with wrap) from rr pointer; register `cmd_id`, clear that `pending` bit, rr pointer ← grant+1 (mod `N_BTN`), `cmd_valid`←1, go OFFER.
- FSM OFFER: hold `cmd_valid`, `cmd_id`; on `cmd_ready` → `cmd_valid`←0, IDLE. Pending bits keep accumulating.
- Simultaneous set and capture-clear of same `pending[i]`: set wins, no overrun.
- `clr_overrun` with same-cycle overrun set: set wins.

## Timing
- Raw edge to `btn_level`: 2 sync edges + `STABLE` ticks (exact cycle count depends on prescaler phase).
- `pending` set on same edge as level rise; `cmd_valid` rises one edge later when IDLE.
- Handshake at edge k → `cmd_valid` low after k; next `cmd_valid` earliest at k+1 (one IDLE cycle). Max throughput one command per 2 cycles.
- `cmd_ready` ignored while `cmd_valid`=0.
- `rst` mid-OFFER: next edge `cmd_valid`=0, command dropped, all state as reset; a still-held button re-qualifies after full debounce and issues a fresh command.

## Structure
- Package `btn_cmd_pkg`: FSM state encoding (IDLE, OFFER), clog2 width function.
- Sub-module `btn_debounce_ch`: synchronizer + counter + level for one button, generated `N_BTN` times; takes `clk`, `rst`, `tick`, raw bit; outputs level and rise pulse.
- Prescaler, pending/overrun registers, arbiter FSM in top.

## Test plan
Use `TICK_DIV`=2, `STABLE`=4, `N_BTN`=4.
- Reset: assert `rst` 3 cycles with all `btn_raw`=1 → all outputs 0 during and first edge after; no command until debounce completes.
- Clean press: `btn_raw[0]` held 1, `cmd_ready`=0 → `btn_level[0]` rises ~10 cycles later, `cmd_valid`=1 next edge with `cmd_id`=0, held stable 10 cycles; `cmd_ready`=1 → one transfer, `cmd_valid` drops.
- Bounce: `btn_raw[2]` toggles every 3 cycles for 60 cycles then returns 0 → `btn_level[2]` stays 0, no command.
- Round-robin: `cmd_id`=0 offered with ready low; meanwhile press btn1 and re-press btn0 (release, press) → after ready high, ids 1 then 0.
- Overrun: ready low, btn3 pressed three times (released between) → first captured as offer, second pending, third sets `overrun[3]`; pulse `clr_overrun` → `overrun`=0.
- Reset mid-offer: `rst` while `cmd_valid`=1 with btn1 held → `cmd_valid`=0, `btn_level`=0; after re-debounce, new `cmd_id`=1 command.

Source files
------------

// File: rtl/btn_cmd_pkg.sv
// Shared types and helpers for the button command scheduler.
package btn_cmd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    // Width needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, tick-qualified stability counter, debounced level.
module btn_debounce_ch
    import btn_cmd_pkg::*;
#(
    parameter int STABLE = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = clog2(STABLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = tick && (sync[1] != level) && (cnt == CNT_LAST);
    assign rise = flip && !level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick) begin
                if (sync[1] != level) begin
                    if (flip) begin
                        level <= ~level;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Debounces N_BTN buttons on a shared tick and serves press events as round-robin
// arbitrated one-shot commands on a single valid/ready port.
module btn_cmd_scheduler
    import btn_cmd_pkg::*;
#(
    parameter int N_BTN    = 4,
    parameter int TICK_DIV = 50000,
    parameter int STABLE   = 19,
    localparam int IDW     = clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic             cmd_valid,
    output logic [IDW-1:0]   cmd_id,
    input  logic             cmd_ready,
    output logic [N_BTN-1:0] overrun,
    input  logic             clr_overrun
);

    localparam int PW = clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [IDW:0]  N_EXT    = (IDW + 1)'(N_BTN);

    arb_state_t       state, state_nxt;
    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] clr_mask;
    logic [N_BTN-1:0] ovr_set;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_nxt;
    logic [IDW-1:0]   grant_idx;
    logic             grant_found;
    logic             capture;
    logic [IDW:0]     cand;
    logic [IDW:0]     gp1;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) pre_cnt <= '0;
        else     pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE(STABLE)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .tick (tick),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (rise[i])
        );
    end

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= N_EXT) cand = cand - N_EXT;
            if (pending[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        gp1 = {1'b0, grant_idx} + 1'b1;
        if (gp1 >= N_EXT) gp1 = '0;
        rr_nxt = gp1[IDW-1:0];
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    capture   = 1'b1;
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (capture) clr_mask[grant_idx] = 1'b1;
    end

    // A press landing on the bit being captured re-arms it instead of counting as lost.
    assign ovr_set = rise & pending & ~clr_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= '0;
            overrun <= '0;
            cmd_id  <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~clr_mask) | rise;
            overrun <= (clr_overrun ? '0 : overrun) | ovr_set;
            if (capture) begin
                cmd_id <= grant_idx;
                rr_ptr <= rr_nxt;
            end
        end
    end

    assign cmd_valid = (state == ST_OFFER);

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Scoreboard bench for btn_cmd_scheduler: directed phases plus randomized button/handshake traffic.
module tb_btn_cmd_scheduler;

    localparam int NB = 4;
    localparam int TD = 2;
    localparam int ST = 4;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic          cmd_valid;
    logic [1:0]    cmd_id;
    logic          cmd_ready;
    logic [NB-1:0] overrun;
    logic          clr_overrun;

    int checks;
    int errors;

    btn_cmd_scheduler #(
        .N_BTN   (NB),
        .TICK_DIV(TD),
        .STABLE  (ST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .cmd_ready  (cmd_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state as it stands after the most recent rising edge.
    int m_pre;
    bit m_s1 [NB];
    bit m_s2 [NB];
    int m_run[NB];
    bit m_lvl[NB];
    bit m_pend[NB];
    bit m_ov [NB];
    bit m_off;
    int m_id;
    int m_rr;
    int exp_q[$];
    int n_xfer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        m_off = 0;
        m_id  = 0;
        m_rr  = 0;
        for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_run[i] = 0;
            m_lvl[i] = 0; m_pend[i] = 0; m_ov[i] = 0;
        end
        exp_q.delete();
    endtask

    // Advance the model across one rising edge given the inputs present at that edge.
    task automatic model_step(input bit r, input logic [NB-1:0] raw, input bit rdy, input bit clr);
        bit rise[NB];
        bit tk;
        int g;
        if (r) begin
            model_reset();
            return;
        end
        tk = (m_pre == TD - 1);
        m_pre = tk ? 0 : m_pre + 1;
        for (int i = 0; i < NB; i++) begin
            rise[i] = 0;
            if (tk) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == ST) begin
                        m_lvl[i] = !m_lvl[i];
                        m_run[i] = 0;
                        rise[i]  = m_lvl[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
        end
        g = -1;
        if (m_off) begin
            if (rdy) m_off = 0;
        end else begin
            for (int k = 0; k < NB; k++)
                if (g < 0 && m_pend[(m_rr + k) % NB]) g = (m_rr + k) % NB;
        end
        if (g >= 0) m_pend[g] = 0;
        if (clr) for (int i = 0; i < NB; i++) m_ov[i] = 0;
        for (int i = 0; i < NB; i++) begin
            if (rise[i]) begin
                if (m_pend[i]) m_ov[i] = 1;
                m_pend[i] = 1;
            end
        end
        if (g >= 0) begin
            m_off = 1;
            m_id  = g;
            m_rr  = (g + 1) % NB;
            exp_q.push_back(g);
        end
    endtask

    initial model_reset();

    // Monitor: compare at the falling edge, score transfers, then advance the model.
    always @(negedge clk) begin
        logic [NB-1:0] e_lvl;
        logic [NB-1:0] e_ov;
        int            e;
        for (int i = 0; i < NB; i++) begin
            e_lvl[i] = m_lvl[i];
            e_ov[i]  = m_ov[i];
        end
        chk("btn_level", 32'(btn_level), 32'(e_lvl));
        chk("overrun", 32'(overrun), 32'(e_ov));
        chk("cmd_valid", 32'(cmd_valid), 32'(m_off));
        if (m_off) chk("cmd_id_hold", 32'(cmd_id), 32'(m_id));
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && rst === 1'b0) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("xfer_unexpected", 32'(cmd_id), 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_id", 32'(cmd_id), 32'(e));
            end
        end
        model_step(rst, btn_raw, cmd_ready, clr_overrun);
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int b, input int hold, input int gap);
        btn_raw[b] = 1'b1;
        wait_cyc(hold);
        btn_raw[b] = 1'b0;
        wait_cyc(gap);
    endtask

    initial begin
        int budget;
        checks      = 0;
        errors      = 0;
        n_xfer      = 0;
        rst         = 1'b1;
        btn_raw     = '1;
        cmd_ready   = 1'b0;
        clr_overrun = 1'b0;

        // Reset with all buttons held, then let every button qualify and drain.
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        cmd_ready = 1'b1;
        wait_cyc(12);
        btn_raw   = '0;
        cmd_ready = 1'b0;
        wait_cyc(30);

        // Clean press held with the consumer stalled, then a single accept.
        btn_raw[0] = 1'b1;
        wait_cyc(25);
        cmd_ready = 1'b1;
        wait_cyc(1);
        cmd_ready = 1'b0;
        wait_cyc(5);
        btn_raw[0] = 1'b0;
        wait_cyc(20);

        // Bouncing input never holds long enough to qualify.
        for (int j = 0; j < 20; j++) begin
            btn_raw[2] = ~btn_raw[2];
            wait_cyc(3);
        end
        btn_raw[2] = 1'b0;
        wait_cyc(20);

        // Round-robin: id0 offered, then btn1 and a second btn0 press queue up.
        press(0, 15, 15);
        btn_raw[1] = 1'b1;
        press(0, 15, 5);
        btn_raw[1] = 1'b0;
        wait_cyc(15);
        cmd_ready = 1'b1;
        wait_cyc(8);
        cmd_ready = 1'b0;

        // Overrun on the third press of btn3 while stalled, then clear.
        for (int j = 0; j < 3; j++) press(3, 15, 15);
        clr_overrun = 1'b1;
        wait_cyc(1);
        clr_overrun = 1'b0;
        wait_cyc(3);
        cmd_ready = 1'b1;
        wait_cyc(6);
        cmd_ready = 1'b0;

        // Reset while a command is offered, button still held.
        btn_raw[1] = 1'b1;
        budget = 100;
        while (cmd_valid !== 1'b1 && budget > 0) begin
            wait_cyc(1);
            budget--;
        end
        chk("offer_before_reset_timeout", 32'(budget > 0), 32'd1);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(30);
        cmd_ready = 1'b1;
        wait_cyc(3);
        btn_raw[1] = 1'b0;
        cmd_ready  = 1'b0;
        wait_cyc(20);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(39) == 0) btn_raw[b] = ~btn_raw[b];
            cmd_ready   = 1'($urandom_range(1));
            clr_overrun = ($urandom_range(99) == 0);
            rst         = ($urandom_range(1999) == 0);
            wait_cyc(1);
        end
        rst         = 1'b0;
        clr_overrun = 1'b0;
        btn_raw     = '0;
        cmd_ready   = 1'b1;
        wait_cyc(60);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("transfers_seen", 32'(n_xfer > 10), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
